// File: rtl/jk_bank_pkg.sv
// Shared command and FSM encodings for the JK status-flag bank arbiter.
// Pure type definitions: no latency, no flow control.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        RST  = 2'b01,
        SET  = 2'b10,
        TOG  = 2'b11
    } jk_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        APPLY = 2'b01,
        ACK   = 2'b10
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flag cell: q updates on the rising edge only while en is high.
// One-cycle update latency; no flow control, the cell holds whenever en is low.
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (en) begin
            case (jk_cmd_t'({j, k}))
                RST:     q <= 1'b0;
                SET:     q <= 1'b1;
                TOG:     q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flag bank; IDLE->APPLY->ACK, 3 cycles per command,
// requesters wait by holding req. Optional err output under macro JK_BANK_ERR_EN.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 6,
    parameter int ADDR_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      cmd,
    input  logic [ADDR_W*NUM_REQ-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      done,
    output logic                      busy,
`ifdef JK_BANK_ERR_EN
    output logic                      err,
`endif
    output logic [WIDTH-1:0]          q,
    output logic [WIDTH-1:0]          qn
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t            state, state_nx;
    logic [IW-1:0]     rr_ptr, win, pick;
    logic              found;
    jk_cmd_t           cmd_q;
    logic [1:0]        jk_bits;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  cell_en;
    logic              out_of_range;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick  = IW'((int'(rr_ptr) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            win    <= '0;
            cmd_q  <= HOLD;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                win    <= pick;
                cmd_q  <= jk_cmd_t'(cmd[2*int'(pick) +: 2]);
                addr_q <= addr[ADDR_W*int'(pick) +: ADDR_W];
            end
            if (state == ACK) begin
                rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt      = '0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (found) state_nx = APPLY;
            end
            APPLY: begin
                gnt      = NUM_REQ'(1) << win;
                state_nx = ACK;
            end
            ACK: begin
                gnt      = NUM_REQ'(1) << win;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Out-of-range addresses match no cell, so the command is simply dropped.
    assign out_of_range = int'(addr_q) >= WIDTH;

    always_comb begin
        cell_en = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cell_en[i] = (state == APPLY) && !out_of_range && (int'(addr_q) == i);
        end
    end

`ifdef JK_BANK_ERR_EN
    assign err = done && out_of_range;
`endif

    assign jk_bits = cmd_q;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (cell_en[g]),
            .j     (jk_bits[1]),
            .k     (jk_bits[0]),
            .q     (q[g]),
            .qn    (qn[g])
        );
    end

endmodule
